// File: rtl/pc_unit_pkg.sv
// Shared CPU definitions: next-PC select codes and PC unit state encodings,
// also used by the control unit.
package pc_unit_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_JR     = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_HALTED  = 2'b01,
        ST_FAULTED = 2'b10
    } pc_state_e;

    // Signed word offset turned into a byte offset
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC multiplexer.
module pc_next_sel
    import pc_unit_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  pc_src_e     pc_src,
    input  logic [15:0] immediate,
    input  logic [31:0] jump_pc,
    input  logic [31:0] reg_data,
    output logic [31:0] next_pc
);

    // Select the candidate PC; all arithmetic wraps modulo 2^32
    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            PC_SEQ:    next_pc = pc_plus4;
            PC_BRANCH: next_pc = pc_plus4 + branch_offset(immediate);
            PC_JUMP:   next_pc = jump_pc;
            PC_JR:     next_pc = reg_data;
            default:   next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter unit: PC register, run/halt/fault FSM, accepted-update counter.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 128
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [15:0] Immediate,
    input  logic [31:0] JumpPC,
    input  logic [31:0] RegData,
    input  logic        Halt,
    output logic [31:0] IAddr,
    output logic [3:0]  PC4,
    output logic [31:0] PCPlus4,
    output logic        RW,
    output logic        Fault,
    output logic [31:0] InstrCount
);

    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

    pc_state_e   state, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] next_pc;

    assign PCPlus4    = pc_q + 32'd4;
    assign PC4        = PCPlus4[31:28];
    assign IAddr      = pc_q;
    assign InstrCount = count_q;
    assign RW         = (state == ST_RUN);
    assign Fault      = (state == ST_FAULTED);

    pc_next_sel u_next_sel (
        .pc_plus4  (PCPlus4),
        .pc_src    (pc_src_e'(PCSrc)),
        .immediate (Immediate),
        .jump_pc   (JumpPC),
        .reg_data  (RegData),
        .next_pc   (next_pc)
    );

    // Next-state and PC/counter update; halt wins over the fault check
    always_comb begin
        state_d = state;
        pc_d    = pc_q;
        count_d = count_q;
        if (state == ST_RUN && PCWre) begin
            if (Halt) begin
                state_d = ST_HALTED;
            end else if (next_pc[1:0] != 2'b00 || next_pc > LAST_ADDR) begin
                state_d = ST_FAULTED;
            end else begin
                pc_d    = next_pc;
                count_d = count_q + 32'd1;
            end
        end
    end

    // State, PC and counter registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= ST_RUN;
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            state   <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table plus randomized
// stimulus against a behavioural model.
module tb_pc_unit;

    localparam int MEM = 128;

    logic        CLK = 1'b0;
    logic        Reset, PCWre, Halt;
    logic [1:0]  PCSrc;
    logic [15:0] Immediate;
    logic [31:0] JumpPC, RegData;
    logic [31:0] IAddr, PCPlus4, InstrCount;
    logic [3:0]  PC4;
    logic        RW, Fault;

    int tests = 0;
    int fails = 0;

    pc_unit #(.RESET_PC(32'h0000_0000), .MEM_BYTES(MEM)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .PCWre      (PCWre),
        .PCSrc      (PCSrc),
        .Immediate  (Immediate),
        .JumpPC     (JumpPC),
        .RegData    (RegData),
        .Halt       (Halt),
        .IAddr      (IAddr),
        .PC4        (PC4),
        .PCPlus4    (PCPlus4),
        .RW         (RW),
        .Fault      (Fault),
        .InstrCount (InstrCount)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          rst;
        bit          wre;
        logic [1:0]  src;
        logic [15:0] imm;
        logic [31:0] jmp;
        logic [31:0] rdat;
        bit          halt;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
        bit          e_rw;
        bit          e_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit wre, logic [1:0] src, logic [15:0] imm,
                                logic [31:0] jmp, logic [31:0] rdat, bit halt,
                                logic [31:0] e_pc, logic [31:0] e_cnt, bit e_rw, bit e_fault);
        vec_t v;
        v.rst = rst; v.wre = wre; v.src = src; v.imm = imm; v.jmp = jmp; v.rdat = rdat;
        v.halt = halt; v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_rw = e_rw; v.e_fault = e_fault;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit wre, input logic [1:0] src, input logic [15:0] imm,
                         input logic [31:0] jmp, input logic [31:0] rdat, input bit halt);
        Reset = rst; PCWre = wre; PCSrc = src; Immediate = imm;
        JumpPC = jmp; RegData = rdat; Halt = halt;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_cnt,
                             input bit e_rw, input bit e_fault);
        logic [31:0] p4;
        p4 = e_pc + 32'd4;
        check({tag, ".IAddr"}, IAddr, e_pc);
        check({tag, ".InstrCount"}, InstrCount, e_cnt);
        check({tag, ".RW"}, {31'd0, RW}, {31'd0, e_rw});
        check({tag, ".Fault"}, {31'd0, Fault}, {31'd0, e_fault});
        check({tag, ".PCPlus4"}, PCPlus4, p4);
        check({tag, ".PC4"}, {28'd0, PC4}, {28'd0, p4[31:28]});
    endtask

    // Behavioural model state: 0 running, 1 halted, 2 faulted
    logic [31:0] m_pc, m_cnt;
    int          m_mode;

    task automatic model_step(input bit rst, input bit wre, input logic [1:0] src,
                              input logic [15:0] imm, input logic [31:0] jmp,
                              input logic [31:0] rdat, input bit halt);
        longint tgt;
        logic [31:0] t;
        if (rst) begin
            m_pc = 0; m_cnt = 0; m_mode = 0;
            return;
        end
        if (m_mode != 0 || !wre) return;
        if (halt) begin
            m_mode = 1;
            return;
        end
        case (src)
            2'd0: tgt = longint'(m_pc) + 4;
            2'd1: tgt = longint'(m_pc) + 4 + longint'($signed(imm)) * 4;
            2'd2: tgt = longint'(jmp);
            default: tgt = longint'(rdat);
        endcase
        t = tgt[31:0];
        if ((t % 4) != 0 || t > MEM - 4) m_mode = 2;
        else begin
            m_pc = t;
            m_cnt = m_cnt + 1;
        end
    endtask

    initial begin
        Reset = 1; PCWre = 0; PCSrc = 0; Immediate = 0; JumpPC = 0; RegData = 0; Halt = 0;

        // rst wre src imm jmp rdat halt | pc cnt rw fault
        vecs.push_back(mk(1, 0, 2'd0, 16'h0000, 0, 0, 0,   0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 2'd0, 16'h0000, 0, 0, 0,   4, 1, 1, 0));
        vecs.push_back(mk(0, 1, 2'd0, 16'h0000, 0, 0, 0,   8, 2, 1, 0));
        vecs.push_back(mk(0, 1, 2'd0, 16'h0000, 0, 0, 0,  12, 3, 1, 0));
        vecs.push_back(mk(0, 1, 2'd1, 16'hFFFE, 0, 0, 0,   8, 4, 1, 0));
        vecs.push_back(mk(0, 1, 2'd1, 16'hFFFE, 0, 0, 0,   4, 5, 1, 0));
        vecs.push_back(mk(0, 1, 2'd1, 16'h0003, 0, 0, 0,  20, 6, 1, 0));
        vecs.push_back(mk(0, 0, 2'd2, 16'h0000, 32'h40, 0, 0, 20, 6, 1, 0));
        vecs.push_back(mk(0, 0, 2'd3, 16'h0000, 0, 32'h3, 0, 20, 6, 1, 0));
        vecs.push_back(mk(0, 0, 2'd1, 16'h8000, 0, 0, 0,  20, 6, 1, 0));
        vecs.push_back(mk(0, 0, 2'd0, 16'h0000, 0, 0, 1,  20, 6, 1, 0));
        vecs.push_back(mk(0, 1, 2'd2, 16'h0000, 32'h40, 0, 0, 64, 7, 1, 0));
        vecs.push_back(mk(0, 1, 2'd3, 16'h0000, 0, 32'h42, 0, 64, 7, 0, 1));
        vecs.push_back(mk(0, 1, 2'd0, 16'h0000, 0, 0, 0,  64, 7, 0, 1));
        vecs.push_back(mk(0, 1, 2'd2, 16'h0000, 32'h8, 0, 1, 64, 7, 0, 1));
        vecs.push_back(mk(1, 1, 2'd2, 16'h0000, 32'h8, 0, 0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 2'd3, 16'h0000, 0, 32'h80, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'd0, 16'h0000, 0, 0, 0,   0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 2'd0, 16'h0000, 0, 0, 0,   0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 2'd3, 16'h0000, 0, 32'h80, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 2'd0, 16'h0000, 0, 0, 0,   0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 2'd0, 16'h0000, 0, 0, 0,   4, 1, 1, 0));
        vecs.push_back(mk(0, 1, 2'd0, 16'h0000, 0, 0, 0,   8, 2, 1, 0));
        vecs.push_back(mk(0, 1, 2'd0, 16'h0000, 0, 0, 0,  12, 3, 1, 0));
        vecs.push_back(mk(0, 1, 2'd0, 16'h0000, 0, 0, 1,  12, 3, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 1, 2'(i), 16'h0001, 32'h10, 32'h20, 0, 12, 3, 0, 0));
        vecs.push_back(mk(1, 1, 2'd2, 16'h0000, 32'h40, 0, 1,  0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 2'd3, 16'h0000, 0, 32'h7C, 0, 124, 1, 1, 0));
        vecs.push_back(mk(0, 1, 2'd0, 16'h0000, 0, 0, 0, 124, 1, 0, 1));
        vecs.push_back(mk(1, 0, 2'd0, 16'h0000, 0, 0, 0,   0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 2'd1, 16'hFFFE, 0, 0, 0,   0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 2'd0, 16'h0000, 0, 0, 0,   0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 2'd3, 16'h0000, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].wre, vecs[i].src, vecs[i].imm,
                  vecs[i].jmp, vecs[i].rdat, vecs[i].halt);
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_cnt,
                      vecs[i].e_rw, vecs[i].e_fault);
        end

        // Randomized run against the model; targets biased towards the store
        model_step(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            bit          rst, wre, halt;
            logic [1:0]  src;
            logic [15:0] imm;
            logic [31:0] jmp, rdat;
            rst  = ($urandom_range(0, 39) == 0);
            wre  = ($urandom_range(0, 3) != 0);
            halt = ($urandom_range(0, 29) == 0);
            src  = 2'($urandom_range(0, 3));
            imm  = 16'($signed($urandom_range(0, 12)) - 6);
            if ($urandom_range(0, 9) == 0) imm = 16'($urandom);
            jmp  = 32'($urandom_range(0, 33)) * 4;
            rdat = 32'($urandom_range(0, 33)) * 4 + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
            model_step(rst, wre, src, imm, jmp, rdat, halt);
            drive(rst, wre, src, imm, jmp, rdat, halt);
            check_all($sformatf("rnd%0d", i), m_pc, m_cnt, m_mode == 0, m_mode == 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
